regfile_wb_ctrl: RTL and testbench
==================================

// Module: regfile_wb_ctrl
// PURPOSE
//  Write-side controller for the 32x32 register file. It owns the regfile write port (wb_en/rd_index/wb_data).
//  It merges single-cycle ALU results with results from the long-latency unit (LU: load/mul/div).
//  LU results are buffered in a small FIFO. A per-register busy scoreboard lets decode stall on pending LU writes.
// PARAMETERS
//  XLEN   32  datapath width
//  DEPTH  2   LU result FIFO entries (>=1)
//  CNT_W  $clog2(DEPTH+1)  width of buf_count
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  rst_n         in   1      synchronous reset, active low
//  alu_wb_valid  in   1      ALU result valid this cycle (cannot be back-pressured)
//  alu_rd        in   5      ALU destination register
//  alu_data      in   XLEN   ALU result
//  lu_valid      in   1      LU result valid
//  lu_ready      out  1      controller accepts LU result
//  lu_rd         in   5      LU destination register
//  lu_data       in   XLEN   LU result
//  issue_en      in   1      LU operation issued this cycle
//  issue_rd      in   5      destination of issued LU op
//  rs1_index     in   5      decode source 1
//  rs2_index     in   5      decode source 2
//  dec_rd        in   5      decode destination
//  stall         out  1      busy[rs1_index] | busy[rs2_index] | busy[dec_rd]
//  wb_en         out  1      regfile write enable
//  rd_index      out  5      regfile write index
//  wb_data       out  XLEN   regfile write data
//  buf_count     out  CNT_W  LU FIFO occupancy
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): wb_en=0, rd_index=0, wb_data=0, busy[31:0]=0, FIFO emptied, buf_count=0.
//    After reset, lu_ready=1. Reset mid-operation discards buffered entries and pending busy bits.
//  - Handshake: an LU push occurs when lu_valid & lu_ready. lu_ready = (buf_count < DEPTH).
//    lu_ready depends only on registered count, so a full FIFO refuses a push even in a pop cycle.
//  - Arbitration, each cycle:
//    - If alu_wb_valid & alu_rd!=0, the ALU wins the port.
//    - Otherwise, if the FIFO is non-empty, pop the head (FIFO order preserved).
//    - Otherwise, the port is idle.
//  - Push and pop in the same cycle: count is unchanged. The pushed entry goes to the tail, never bypassing the head.
//  - Latency: the write-port outputs are registered.
//    - Winner at cycle N: wb_en=1, rd_index/wb_data valid in cycle N+1.
//    - Idle cycle: wb_en=0; rd_index/wb_data hold their last value.
//  - Minimum LU latency is lu_valid at N -> push at N -> pop at N+1 -> wb_en at N+2 (empty FIFO, no ALU).
//  - x0: an ALU result with rd=0 is dropped, not granted, and does not block a pop.
//    An LU entry with rd=0 is accepted and popped normally, but produces wb_en=0.
//    issue_rd=0 sets no busy bit. wb_en is never 1 with rd_index=0.
//  - Scoreboard:
//    - issue_en & issue_rd!=0 sets busy[issue_rd] at posedge.
//    - The pop of an LU entry for rd clears busy[rd] at the same posedge that raises wb_en for it.
//    - Set and clear of the same index in one cycle: set wins.
//  - stall is combinational from the busy vector (not registered) and is 0 after reset.
//  - Decode contract: issue and ALU results never target a busy rd (guaranteed via stall on dec_rd).
//    The controller does not check this.
//  - FIFO pointers are mod-DEPTH and wrap; buf_count ranges 0..DEPTH.
// TESTING
//  1 Reset: hold rst_n=0 2 cycles with lu_valid=1 -> wb_en=0, buf_count=0, stall=0. lu_ready=1 after release.
//  2 ALU: alu_wb_valid=1, alu_rd=5, alu_data=0x00001234 at N -> wb_en=1, rd_index=5, wb_data=0x1234 at N+1; wb_en=0 at N+2.
//  3 LU: issue_en, issue_rd=7 at N; rs1_index=7 -> stall=1.
//    lu_valid, lu_rd=7, lu_data=0xDEADBEEF at N+3 -> wb_en=1, rd_index=7 at N+5; stall=0 from N+5.
//  4 Contention: alu_wb_valid=1 for 4 cycles; LU pushes rd=8 then rd=9.
//    -> buf_count=2, lu_ready=0, third push refused. After ALU stops, writes are rd 8 then rd 9 on consecutive cycles.
//  5 x0: alu_rd=0 with FIFO holding rd=3 -> rd 3 written next cycle.
//    lu_rd=0 -> no wb_en. issue_rd=0 -> stall stays 0.
//  6 Reset mid-run: FIFO holds 2 entries, busy[8]=1, rst_n=0 one cycle -> buf_count=0, stall=0, no stale writes afterwards.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller that merges ALU results with buffered long-latency results.
// It also tracks per-register busy bits so decode can stall on pending long-latency writes.
module regfile_wb_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_wb_valid,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [4:0]       lu_rd,
  input  logic [XLEN-1:0]  lu_data,
  input  logic             issue_en,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       rs1_index,
  input  logic [4:0]       rs2_index,
  input  logic [4:0]       dec_rd,
  output logic             stall,
  output logic             wb_en,
  output logic [4:0]       rd_index,
  output logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] buf_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } lu_entry_t;

  lu_entry_t        fifo_q [DEPTH];
  lu_entry_t        fifo_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      busy_q, busy_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       rd_index_q, rd_index_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;

  logic      alu_win;
  logic      push;
  logic      pop;
  lu_entry_t head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Acceptance looks only at the registered count: a full buffer refuses even while popping.
  assign lu_ready = (count_q < CNT_W'(DEPTH));
  assign alu_win  = alu_wb_valid && (alu_rd != 5'd0);
  assign push     = lu_valid && lu_ready;
  assign pop      = !alu_win && (count_q != '0);
  assign head     = fifo_q[rd_ptr_q];
  assign stall    = busy_q[rs1_index] | busy_q[rs2_index] | busy_q[dec_rd];

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    busy_d     = busy_q;
    wb_en_d    = 1'b0;
    rd_index_d = rd_index_q;
    wb_data_d  = wb_data_q;

    if (alu_win) begin
      wb_en_d    = 1'b1;
      rd_index_d = alu_rd;
      wb_data_d  = alu_data;
    end else if (pop && (head.rd != 5'd0)) begin
      wb_en_d        = 1'b1;
      rd_index_d     = head.rd;
      wb_data_d      = head.data;
      busy_d[head.rd] = 1'b0;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      fifo_d[wr_ptr_q] = '{rd: lu_rd, data: lu_data};
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Applied after the pop clear so a same-cycle issue to the same register keeps it busy.
    if (issue_en && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      wb_en_q    <= 1'b0;
      rd_index_q <= '0;
      wb_data_q  <= '0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      wb_en_q    <= wb_en_d;
      rd_index_q <= rd_index_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_en     = wb_en_q;
  assign rd_index  = rd_index_q;
  assign wb_data   = wb_data_q;
  assign buf_count = count_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed, table-driven bench for regfile_wb_ctrl with hand-computed expectations.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_wb_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [4:0]  dec_rd;
  logic        stall;
  logic        wb_en;
  logic [4:0]  rd_index;
  logic [31:0] wb_data;
  logic [1:0]  buf_count;

  int tests = 0;
  int fails = 0;

  regfile_wb_ctrl #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_valid(alu_wb_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .rs1_index(rs1_index), .rs2_index(rs2_index), .dec_rd(dec_rd),
    .stall(stall), .wb_en(wb_en), .rd_index(rd_index), .wb_data(wb_data),
    .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lu_v;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        iss;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1, rs2, drd;
    logic        e_wb;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [1:0]  e_cnt;
    logic        e_stall;
    logic        e_ready;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
    input logic iv, input logic [4:0] ird,
    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dr,
    input logic ewb, input logic [4:0] erd, input logic [31:0] edat,
    input logic [1:0] ecnt, input logic est, input logic erdy);
    vec_t v;
    v.alu_v = av;  v.alu_rd = ard; v.alu_data = adat;
    v.lu_v  = lv;  v.lu_rd  = lrd; v.lu_data  = ldat;
    v.iss   = iv;  v.iss_rd = ird;
    v.rs1   = r1;  v.rs2    = r2;  v.drd      = dr;
    v.e_wb  = ewb; v.e_rd   = erd; v.e_data   = edat;
    v.e_cnt = ecnt; v.e_stall = est; v.e_ready = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_wb_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    issue_en = 1'b0; issue_rd = '0;
    rs1_index = '0; rs2_index = '0; dec_rd = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset held two cycles while the LU is offering a result.
    lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'hCAFE0000;
    step();
    step();
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_count", 32'(buf_count), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rd_index", 32'(rd_index), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    lu_valid = 1'b0;
    #1;
    chk("rst_ready", 32'(lu_ready), 32'd1);

    //              alu              lu                      issue    rs1 rs2 drd  exp: wb rd data          cnt st rdy
    vq.push_back(mk(1, 5, 32'h1234,  0, 0, 0,                0, 0,    0,  0,  0,   1, 5, 32'h1234,      0, 0, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                0, 0,    0,  0,  0,   0, 0, 0,             0, 0, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                1, 7,    7,  0,  0,   0, 0, 0,             0, 1, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                0, 0,    7,  0,  0,   0, 0, 0,             0, 1, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                0, 0,    7,  0,  0,   0, 0, 0,             0, 1, 1));
    vq.push_back(mk(0, 0, 0,         1, 7, 32'hDEADBEEF,     0, 0,    7,  0,  0,   0, 0, 0,             1, 1, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                0, 0,    7,  0,  0,   1, 7, 32'hDEADBEEF,  0, 0, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                1, 8,    0,  0,  8,   0, 0, 0,             0, 1, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                1, 9,    0,  0,  9,   0, 0, 0,             0, 1, 1));
    vq.push_back(mk(1, 1, 32'h11,    1, 8, 32'h88,           0, 0,    8,  0,  0,   1, 1, 32'h11,        1, 1, 1));
    vq.push_back(mk(1, 2, 32'h22,    1, 9, 32'h99,           0, 0,    9,  0,  0,   1, 2, 32'h22,        2, 1, 0));
    vq.push_back(mk(1, 3, 32'h33,    1, 10, 32'hAA,          0, 0,    0,  0,  0,   1, 3, 32'h33,        2, 0, 0));
    vq.push_back(mk(1, 4, 32'h44,    1, 10, 32'hAA,          0, 0,    0,  0,  0,   1, 4, 32'h44,        2, 0, 0));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                0, 0,    8,  0,  0,   1, 8, 32'h88,        1, 0, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                0, 0,    0,  9,  0,   1, 9, 32'h99,        0, 0, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                0, 0,    0,  0,  0,   0, 0, 0,             0, 0, 1));
    vq.push_back(mk(1, 0, 32'hFF,    1, 3, 32'h333,          0, 0,    0,  0,  0,   0, 0, 0,             1, 0, 1));
    vq.push_back(mk(1, 0, 32'hEE,    0, 0, 0,                0, 0,    0,  0,  0,   1, 3, 32'h333,       0, 0, 1));
    vq.push_back(mk(0, 0, 0,         1, 0, 32'h5,            0, 0,    0,  0,  0,   0, 0, 0,             1, 0, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                0, 0,    0,  0,  0,   0, 0, 0,             0, 0, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                1, 0,    0,  0,  0,   0, 0, 0,             0, 0, 1));
    vq.push_back(mk(0, 0, 0,         1, 12, 32'hC1,          0, 0,    0,  0,  0,   0, 0, 0,             1, 0, 1));
    vq.push_back(mk(0, 0, 0,         1, 13, 32'hC2,          0, 0,    0,  0,  0,   1, 12, 32'hC1,       1, 0, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                0, 0,    0,  0,  0,   1, 13, 32'hC2,       0, 0, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                1, 14,   14, 0,  0,   0, 0, 0,             0, 1, 1));
    vq.push_back(mk(0, 0, 0,         1, 14, 32'hE0,          0, 0,    14, 0,  0,   0, 0, 0,             1, 1, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                1, 14,   14, 0,  0,   1, 14, 32'hE0,       0, 1, 1));
    vq.push_back(mk(0, 0, 0,         1, 14, 32'hE1,          0, 0,    14, 0,  0,   0, 0, 0,             1, 1, 1));
    vq.push_back(mk(0, 0, 0,         0, 0, 0,                0, 0,    14, 0,  0,   1, 14, 32'hE1,       0, 0, 1));

    foreach (vq[i]) begin
      alu_wb_valid = vq[i].alu_v; alu_rd = vq[i].alu_rd; alu_data = vq[i].alu_data;
      lu_valid = vq[i].lu_v; lu_rd = vq[i].lu_rd; lu_data = vq[i].lu_data;
      issue_en = vq[i].iss; issue_rd = vq[i].iss_rd;
      rs1_index = vq[i].rs1; rs2_index = vq[i].rs2; dec_rd = vq[i].drd;
      step();
      chk($sformatf("v%0d_wb_en", i), 32'(wb_en), 32'(vq[i].e_wb));
      if (vq[i].e_wb) begin
        chk($sformatf("v%0d_rd_index", i), 32'(rd_index), 32'(vq[i].e_rd));
        chk($sformatf("v%0d_wb_data", i), wb_data, vq[i].e_data);
      end
      chk($sformatf("v%0d_count", i), 32'(buf_count), 32'(vq[i].e_cnt));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vq[i].e_stall));
      chk($sformatf("v%0d_ready", i), 32'(lu_ready), 32'(vq[i].e_ready));
    end

    // Reset in the middle of activity: two buffered entries and a pending busy bit.
    idle_inputs();
    issue_en = 1'b1; issue_rd = 5'd8;
    step();
    issue_en = 1'b0;
    alu_wb_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'h800;
    step();
    lu_rd = 5'd9; lu_data = 32'h900;
    step();
    rs1_index = 5'd8;
    #1;
    chk("mid_pre_count", 32'(buf_count), 32'd2);
    chk("mid_pre_stall", 32'(stall), 32'd1);
    alu_wb_valid = 1'b0; lu_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mid_rst_count", 32'(buf_count), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_wb_en", 32'(wb_en), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mid_post%0d_wb_en", k), 32'(wb_en), 32'd0);
      chk($sformatf("mid_post%0d_count", k), 32'(buf_count), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
